lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
- Sequences the character-display write path: drives `ascii_data` and `write` into the display controller and generates the panel enable strobe.
- After reset it runs the HD44780-style power-on wait and init command list.
- It then refreshes the display from a 16-byte line buffer on request.
- Sits between the STM32-facing register interface (buffer writes, refresh request) and the display controller.

Parameters:
- PWR_WAIT, 750000: cycles held idle after reset before the first command (15 ms at 50 MHz).
- SETUP_CYC, 4: cycles `ascii_data`/`write` are stable before `lcd_en` rises.
- EN_CYC, 12: cycles `lcd_en` is high.
- HOLD_CYC, 4: cycles `ascii_data`/`write` are held after `lcd_en` falls.
- CMD_WAIT, 2500: gap cycles after every byte except clear.
- CLR_WAIT, 80000: gap cycles after clear command 0x01.
- LINE_LEN, 16: line buffer depth. Power of two, max 64.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- buf_we  in  1  line buffer write strobe
- buf_addr  in  log2(LINE_LEN)  buffer write address
- buf_wdata  in  8  ASCII character to store
- refresh  in  1  single-cycle request to redraw line 1
- init_done  out  1  high once the init list has completed
- busy  out  1  high whenever the FSM is not in IDLE
- ascii_data  out  8  byte presented to the display controller
- write  out  1  1 = data byte, 0 = command byte
- lcd_en  out  1  panel enable strobe

Behaviour:
- Reset state, asserted asynchronously:
  - FSM = PWR; all counters cleared; pending cleared.
  - Buffer filled with 0x20 (space).
  - init_done=0, busy=1, ascii_data=0x00, write=0, lcd_en=0.
- Reset mid-operation: `lcd_en` drops in the same instant; no partial byte is resumed; power wait restarts on release.
- States:
  - PWR: count PWR_WAIT cycles, then go to SETUP with init byte 0.
  - SETUP: drive byte and `write`, `lcd_en`=0, SETUP_CYC cycles, then PULSE.
  - PULSE: `lcd_en`=1 for EN_CYC cycles, then HOLD.
  - HOLD: `lcd_en`=0, byte and `write` unchanged, HOLD_CYC cycles, then GAP.
  - GAP: count CLR_WAIT if the byte was command 0x01, else CMD_WAIT. Then advance the byte index and:
    - more bytes in the sequence: go to SETUP;
    - sequence finished: go to IDLE.
  - IDLE: busy=0.
    - `refresh` or `pending` set: clear `pending`, go to SETUP with the frame start.
- Init sequence, all with write=0: 0x38, 0x38, 0x0C, 0x06, 0x01.
  - `init_done` rises on the cycle IDLE is first entered and stays high until reset.
- Refresh frame: command 0x80 (write=0), then buf[0]..buf[LINE_LEN-1] (write=1). Total LINE_LEN+1 bytes.
- Per-byte time = SETUP_CYC + EN_CYC + HOLD_CYC + gap.
  - Each phase counter loads N-1 on entry and exits at 0.
  - Every phase parameter is required ≥ 1.
- Characters are sampled from the buffer on SETUP entry.
  - A buffer write to a character not yet sampled is shown in the current frame.
  - A write to an already-sent character is shown in the next frame only.
- Buffer write and read of the same address in one cycle: the read returns the old value.
- `refresh` before init_done, or while busy: sets `pending`.
  - Multiple requests collapse into exactly one extra frame.
  - A request in the same cycle IDLE is left does not set pending.
- `ascii_data` and `write` change only on SETUP entry, never during PULSE or HOLD.
- Byte index wraps only through IDLE. No out-of-range buffer read is possible.

Test Plan:
- Reset release, PARAMS small (PWR_WAIT=10, CMD_WAIT=5, CLR_WAIT=20) -> first `lcd_en` rise at cycle 10+4 after release; bytes 0x38,0x38,0x0C,0x06,0x01 with write=0; init_done rises after the 0x01 gap of 20.
- Write "HELLO" to addr 0-4, then pulse refresh -> 0x80 (write=0), then 'H','E','L','L','O' followed by 11×0x20 (write=1); busy drops after the 17th gap.
- Measure the strobe on any byte -> `lcd_en` high for exactly 12 cycles; data stable 4 cycles before the rise and 4 cycles after the fall.
- Pulse refresh 3 times during a frame -> exactly one further frame, started immediately on IDLE.
- During a frame, write 'Z' to addr 15 before char 15 and to addr 0 after char 0 -> current frame shows 'Z' at 15 and the old char at 0; the next frame shows both.
- Assert rst mid-PULSE -> `lcd_en`=0 and init_done=0 immediately; after release the full power wait and init list repeat, and buffer contents are 0x20.

Source files
------------

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780-style write sequencer. Runs the power-on wait and
// init command list after reset, then redraws line 1 from a small character
// buffer whenever a refresh is requested. Each byte is presented with setup,
// enable pulse, hold and a post-byte gap before the next one.
`timescale 1ns/1ps
module lcd_sequencer #(
  parameter int PWR_WAIT  = 750000,
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 4,
  parameter int CMD_WAIT  = 2500,
  parameter int CLR_WAIT  = 80000,
  parameter int LINE_LEN  = 16,
  localparam int AW       = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_wdata,
  input  logic          refresh,
  output logic          init_done,
  output logic          busy,
  output logic [7:0]    ascii_data,
  output logic          write,
  output logic          lcd_en
);

  // Index must cover both the 5-entry init list and the LINE_LEN+1 frame.
  localparam int IDX_W = ($clog2(LINE_LEN + 1) > 3) ? $clog2(LINE_LEN + 1) : 3;

  localparam logic [31:0] PWR_LAST   = 32'(PWR_WAIT - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT - 1);

  localparam logic [IDX_W-1:0] INIT_LAST_IDX  = IDX_W'(4);
  localparam logic [IDX_W-1:0] FRAME_LAST_IDX = IDX_W'(LINE_LEN);

  typedef enum logic [2:0] {
    S_PWR, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_q, frame_d;     // 0 = init list, 1 = refresh frame
  logic             pending_q, pending_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       data_q, data_d;
  logic             write_q, write_d;
  logic [7:0]       buf_q [LINE_LEN];

  logic             load;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_frame;
  logic [AW-1:0]    rd_addr;
  logic [IDX_W-1:0] last_idx;

  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0), IDX_W'(1): return 8'h38;  // function set, sent twice
      IDX_W'(2):            return 8'h0C;  // display on, cursor off
      IDX_W'(3):            return 8'h06;  // entry mode increment
      default:              return 8'h01;  // clear display
    endcase
  endfunction

  // Line buffer: register interface writes; a same-cycle read sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINE_LEN; i++) buf_q[i] <= 8'h20;
    end else if (buf_we) begin
      buf_q[buf_addr] <= buf_wdata;
    end
  end

  // Sequencer state and byte registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_PWR;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      data_q      <= 8'h00;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      data_q      <= data_d;
      write_q     <= write_d;
    end
  end

  // Next-state: phase counters load N-1 on entry and leave at zero; the byte
  // and its write flag are latched only when SETUP is entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    data_d      = data_q;
    write_d     = write_q;
    load        = 1'b0;
    ld_idx      = idx_q;
    ld_frame    = frame_q;
    rd_addr     = '0;
    last_idx    = frame_q ? FRAME_LAST_IDX : INIT_LAST_IDX;

    // Requests outside IDLE collapse into a single pending frame.
    if (refresh && (state_q != S_IDLE)) pending_d = 1'b1;

    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          load     = 1'b1;
          ld_idx   = '0;
          ld_frame = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = EN_LAST;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = (!write_q && (data_q == 8'h01)) ? CLR_LAST : CMD_LAST;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == last_idx) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            init_done_d = 1'b1;
          end else begin
            load   = 1'b1;
            ld_idx = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_IDLE: begin
        if (refresh || pending_q) begin
          load      = 1'b1;
          ld_idx    = '0;
          ld_frame  = 1'b1;
          pending_d = 1'b0;
        end
      end
      default: state_d = S_PWR;
    endcase

    if (load) begin
      state_d = S_SETUP;
      cnt_d   = SETUP_LAST;
      idx_d   = ld_idx;
      frame_d = ld_frame;
      if (!ld_frame) begin
        data_d  = init_byte(ld_idx);
        write_d = 1'b0;
      end else if (ld_idx == '0) begin
        data_d  = 8'h80;               // set DDRAM address to line 1 start
        write_d = 1'b0;
      end else begin
        rd_addr = AW'(ld_idx - IDX_W'(1));
        data_d  = buf_q[rd_addr];
        write_d = 1'b1;
      end
    end
  end

  assign init_done  = init_done_q;
  assign busy       = (state_q != S_IDLE);
  assign ascii_data = data_q;
  assign write      = write_q;
  assign lcd_en     = (state_q == S_PULSE);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with small timing parameters. Expected
// bytes go into a queue as stimulus is applied; a negedge monitor records each
// strobed byte with its pulse width and setup/hold stability, and the main
// sequence pops both queues and compares.
`timescale 1ns/1ps
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buf_we = 1'b0;
  logic [3:0] buf_addr = 4'd0;
  logic [7:0] buf_wdata = 8'h00;
  logic       refresh = 1'b0;
  logic       init_done, busy, write, lcd_en;
  logic [7:0] ascii_data;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .PWR_WAIT(10), .SETUP_CYC(4), .EN_CYC(12), .HOLD_CYC(4),
    .CMD_WAIT(5), .CLR_WAIT(20), .LINE_LEN(16)
  ) dut (
    .clk(clk), .rst(rst), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .refresh(refresh), .init_done(init_done),
    .busy(busy), .ascii_data(ascii_data), .write(write), .lcd_en(lcd_en)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0]  exp_q[$];   // {write, byte}
  logic [16:0] obs_q[$];   // {setup_ok, hold_ok, width[5:0], write, byte}
  logic [7:0]  model_buf [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor
  logic [8:0] hist [4];
  logic [8:0] mon_cur, mon_rec;
  logic       en_prev = 1'b0;
  logic       s_ok, h_ok;
  int         phase = 0, width = 0, hold_n = 0;

  always @(negedge clk) begin
    mon_cur = {write, ascii_data};
    if (!rst) begin
      phase = 0;
    end else if (lcd_en && !en_prev) begin
      mon_rec = mon_cur;
      s_ok    = (hist[0] == mon_cur) && (hist[1] == mon_cur) &&
                (hist[2] == mon_cur) && (hist[3] == mon_cur);
      h_ok    = 1'b1;
      width   = 1;
      phase   = 1;
    end else if (phase == 1) begin
      if (mon_cur != mon_rec) h_ok = 1'b0;
      if (lcd_en) begin
        width++;
      end else begin
        phase  = 2;
        hold_n = 1;
      end
    end else if (phase == 2) begin
      if (mon_cur != mon_rec) h_ok = 1'b0;
      hold_n++;
    end
    if (phase == 2 && hold_n == 4) begin
      obs_q.push_back({s_ok, h_ok, 6'(width), mon_rec});
      phase = 0;
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = mon_cur;
    en_prev = lcd_en;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_buf[i]});
  endtask

  task automatic drain(input string tag);
    logic [8:0]  e;
    logic [16:0] o;
    int          k;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_b%0d", tag, k), 32'(o), 32'({1'b1, 1'b1, 6'd12, e}));
      k++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wbuf(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    buf_we = 1'b1; buf_addr = a; buf_wdata = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic pulse_refresh(output int t);
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    t = cyc;
  endtask

  task automatic wait_en(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (lcd_en === 1'b1) begin n = i; break; end
    end
  endtask

  // which: 0 = busy, 1 = init_done; returns the cycle the level was seen
  task automatic wait_sig(input int which, input logic lvl, input int max, output int t);
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (((which == 0) ? busy : init_done) === lvl) begin t = cyc; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, t1, t2, tr, rel, dummy;
    for (int i = 0; i < 16; i++) model_buf[i] = 8'h20;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_data", 32'(ascii_data), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_en", 32'(lcd_en), 32'd0);

    // Power wait and init list
    @(negedge clk); rst = 1'b1; rel = cyc;
    push_init();
    wait_en(100, n);
    chk("first_en_cycle", n, 14);
    wait_sig(1, 1'b1, 400, t);
    chk("init_done_cycle", t - rel, 150);
    chk("idle_after_init", 32'(busy), 32'd0);
    drain("init");

    // HELLO frame
    wbuf(4'd0, "H"); wbuf(4'd1, "E"); wbuf(4'd2, "L"); wbuf(4'd3, "L"); wbuf(4'd4, "O");
    model_buf[0] = "H"; model_buf[1] = "E"; model_buf[2] = "L";
    model_buf[3] = "L"; model_buf[4] = "O";
    pulse_refresh(tr);
    push_frame();
    wait_sig(0, 1'b0, 1000, t);
    chk("hello_frame_len", t - tr, 425);
    drain("hello");

    // Three requests during a frame give exactly one more frame
    pulse_refresh(tr);
    push_frame(); push_frame();
    for (int i = 0; i < 3; i++) begin
      repeat (40) @(negedge clk);
      pulse_refresh(dummy);
    end
    wait_sig(0, 1'b0, 1000, t1);
    chk("pend_frame1_len", t1 - tr, 425);
    @(posedge clk); #1;
    chk("pend_restart_immediate", 32'(busy), 32'd1);
    wait_sig(0, 1'b0, 1000, t2);
    chk("pend_frame2_len", t2 - t1, 426);
    repeat (60) @(posedge clk); #1;
    chk("pend_no_third_frame", 32'(busy), 32'd0);
    drain("pend");

    // Buffer writes during a frame: char 15 not yet sent, char 0 already sent
    pulse_refresh(tr);
    model_buf[15] = "Z"; push_frame();
    model_buf[0]  = "Z"; push_frame();
    repeat (100) @(negedge clk);
    wbuf(4'd15, "Z");
    wbuf(4'd0, "Z");
    pulse_refresh(dummy);
    wait_sig(0, 1'b0, 1000, t1);
    chk("zfr_frame1_len", t1 - tr, 425);
    wait_sig(0, 1'b0, 1000, t2);
    chk("zfr_frame2_len", t2 - t1, 426);
    drain("zfr");

    // Reset in the middle of an enable pulse
    pulse_refresh(tr);
    wait_en(100, n);
    chk("refresh_first_en", n, 4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_en", 32'(lcd_en), 32'd0);
    chk("rstmid_init_done", 32'(init_done), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) model_buf[i] = 8'h20;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; rel = cyc;
    push_init();
    wait_en(100, n);
    chk("reinit_first_en_cycle", n, 14);
    wait_sig(1, 1'b1, 400, t);
    chk("reinit_done_cycle", t - rel, 150);
    drain("reinit");

    pulse_refresh(tr);
    push_frame();
    wait_sig(0, 1'b0, 1000, t);
    chk("blank_frame_len", t - tr, 425);
    drain("blank");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
